// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input conditioning block.
package gpio_pkg;
  localparam int GPIO_W             = 32;
  localparam int DEF_WIDTH          = 18;
  localparam int DEF_CLK_HZ         = 50_000_000;
  localparam int DEF_SAMPLE_HZ      = 1000;
  localparam int DEF_STABLE_SAMPLES = 4;

  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a tick-sampled stability filter.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);
  localparam int CW = cnt_width(STABLE_SAMPLES);

  logic          meta_q, sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      // Any matching sample restarts the run, so only consecutive differences count.
      if (sync_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_SAMPLES - 1)) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
endmodule

// File: rtl/gpio_in_debounce.sv
// Board input conditioner: per-bit debounce, edge pulses, zero-padded GPIO word.
// Optional GPIO_IN_STICKY_EN adds a sticky change flag on gpio_in[31] with clr_sticky.
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int SAMPLE_HZ      = DEF_SAMPLE_HZ,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
`ifdef GPIO_IN_STICKY_EN
  input  logic              clr_sticky,
`endif
  input  logic [WIDTH-1:0]  raw_in,
  output logic [GPIO_W-1:0] gpio_in,
  output logic [WIDTH-1:0]  rise,
  output logic [WIDTH-1:0]  fall,
  output logic              changed
);
  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int DW  = $clog2(DIV);

  logic [DW-1:0]    div_q, div_d;
  logic             tick;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] dbn_q, dbn_d;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic             changed_q, changed_d;

  assign tick = (div_q == DW'(DIV - 1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_bit (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .raw    (raw_in[i]),
      .stable (stable[i])
    );
  end

  // dbn_q lags stable by one cycle, so the edge pulses line up with the word update.
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    dbn_d     = stable;
    rise_d    = stable & ~dbn_q;
    fall_d    = ~stable & dbn_q;
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      dbn_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      dbn_q     <= dbn_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

`ifdef GPIO_IN_STICKY_EN
  logic sticky_q, sticky_d;

  // A visible changed pulse beats a simultaneous clear.
  always_comb begin
    sticky_d = changed_q | (sticky_q & ~clr_sticky);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end
`endif

  always_comb begin
    gpio_in            = '0;
    gpio_in[WIDTH-1:0] = dbn_q;
`ifdef GPIO_IN_STICKY_EN
    gpio_in[GPIO_W-1]  = sticky_q;
`endif
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce at DIV=10, STABLE_SAMPLES=4, WIDTH=18.
module tb_gpio_in_debounce;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  raw_in;
  logic [31:0]   gpio_in;
  logic [W-1:0]  rise, fall;
  logic          changed;
`ifdef GPIO_IN_STICKY_EN
  logic          clr_sticky;
`endif

  gpio_in_debounce #(
    .WIDTH(W), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_SAMPLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef GPIO_IN_STICKY_EN
    .clr_sticky (clr_sticky),
`endif
    .raw_in     (raw_in),
    .gpio_in    (gpio_in),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // Edges since reset release; sample ticks are evaluated on multiples of 10.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_chk = 0, n_fail = 0;
  int n_chg;
  logic [W-1:0] rise_acc, fall_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_acc();
    n_chg = 0; rise_acc = '0; fall_acc = '0;
  endtask

  task automatic sample();
    @(posedge clk); #1;
    if (changed) n_chg++;
    rise_acc |= rise;
    fall_acc |= fall;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) sample();
  endtask

  task automatic wait_gpio(input logic [W-1:0] tgt, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      sample();
      if (gpio_in[W-1:0] == tgt) begin lat = i; break; end
    end
  endtask

  // Change applied just after edge e: sync at e+2, first usable tick at the next
  // multiple of 10 >= e+3, acceptance three ticks later, output one edge after.
  function automatic int exp_lat(input int e);
    return ((e + 3 + 9) / 10) * 10 + 31 - e;
  endfunction

  int lat, e;

  initial begin
    rst = 1'b1; raw_in = 18'h3FFFF;
`ifdef GPIO_IN_STICKY_EN
    clr_sticky = 1'b0;
`endif
    // Reset with all inputs high
    repeat (3) @(posedge clk); #1;
    chk("rst_gpio", gpio_in, 32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_chg", 32'(changed), 32'h0);
    rst = 1'b0; clr_acc();
    wait_gpio(18'h3FFFF, 60, lat);
    chk("pwr_lat", 32'(lat), 32'd41);
    chk("pwr_gpio", gpio_in, 32'h0003FFFF);
    chk("pwr_rise", 32'(rise), 32'h3FFFF);
    chk("pwr_chg", 32'(changed), 32'h1);
    run(1);
    chk("pwr_rise_1cyc", 32'(rise), 32'h0);
    chk("pwr_chg_1cyc", 32'(changed), 32'h0);
    run(5);
    chk("pwr_nchg", 32'(n_chg), 32'd1);
    chk("pwr_fall_none", 32'(fall_acc), 32'h0);

    // All bits released together
    e = cyc; raw_in = '0; clr_acc();
    wait_gpio(18'h0, 60, lat);
    chk("fall_lat", 32'(lat), 32'(exp_lat(e)));
    chk("fall_vec", 32'(fall), 32'h3FFFF);
    run(3);
    chk("fall_nchg", 32'(n_chg), 32'd1);

    // Clean step on bit 0
    e = cyc; raw_in[0] = 1'b1; clr_acc();
    wait_gpio(18'h1, 60, lat);
    chk("step_lat", 32'(lat), 32'(exp_lat(e)));
    chk("step_rise", 32'(rise), 32'h1);
    run(3);
    chk("step_fall_none", 32'(fall_acc), 32'h0);
    chk("step_nchg", 32'(n_chg), 32'd1);

    // 25-cycle glitch on bit 5
    clr_acc(); raw_in[5] = 1'b1;
    run(25);
    raw_in[5] = 1'b0;
    run(60);
    chk("glitch_gpio", gpio_in, 32'h1 | (gpio_in & 32'h8000_0000));
    chk("glitch_rise", 32'(rise_acc), 32'h0);
    chk("glitch_fall", 32'(fall_acc), 32'h0);
    chk("glitch_nchg", 32'(n_chg), 32'd0);

    // Chatter on bit 2 every 7 cycles, then hold high
    clr_acc();
    for (int k = 0; k < 28; k++) begin
      raw_in[2] = ~raw_in[2];
      run(7);
    end
    chk("chat_gpio", 32'(gpio_in[W-1:0]), 32'h1);
    chk("chat_nchg", 32'(n_chg), 32'd0);
    raw_in[2] = 1'b1;
    wait_gpio(18'h5, 60, lat);
    chk("chat_found", 32'(lat > 0), 32'h1);
    run(3);
    chk("chat_rise", 32'(rise_acc), 32'h4);
    chk("chat_nchg", 32'(n_chg), 32'd1);

    // Reset two ticks into a count on bit 1
    raw_in[1] = 1'b1;
    run(25);
    rst = 1'b1; #1;
    chk("mid_rst_gpio", gpio_in, 32'h0);
    chk("mid_rst_rise", 32'(rise), 32'h0);
    chk("mid_rst_chg", 32'(changed), 32'h0);
    run(2);
    rst = 1'b0; clr_acc();
    wait_gpio(18'h7, 60, lat);
    chk("mid_rst_lat", 32'(lat), 32'd41);
    chk("mid_rst_rise_vec", 32'(rise), 32'h7);

`ifdef GPIO_IN_STICKY_EN
    // changed is high in this cycle; sticky follows on the next edge
    chk("stk_pre", 32'(gpio_in[31]), 32'h0);
    run(1);
    chk("stk_set", 32'(gpio_in[31]), 32'h1);
    run(5);
    chk("stk_hold", 32'(gpio_in[31]), 32'h1);
    clr_sticky = 1'b1; run(1); clr_sticky = 1'b0;
    chk("stk_clr", 32'(gpio_in[31]), 32'h0);
    raw_in[3] = 1'b1;
    wait_gpio(18'hF, 60, lat);
    chk("stk_chg", 32'(changed), 32'h1);
    clr_sticky = 1'b1; run(1); clr_sticky = 1'b0;
    chk("stk_set_wins", 32'(gpio_in[31]), 32'h1);
    run(3);
    chk("stk_hold2", 32'(gpio_in[31]), 32'h1);
    clr_sticky = 1'b1; run(1); clr_sticky = 1'b0;
    chk("stk_clr2", 32'(gpio_in[31]), 32'h0);
`else
    chk("pad_bits", 32'(gpio_in[31:W]), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
